// File: rtl/demux_write_arbiter_pkg.sv
// Shared widths, requester indices and the write-port state decode for the
// writeback demux arbiter.
package demux_write_arbiter_pkg;

    localparam int DATA_W    = 20;
    localparam int REGADDR_W = 4;
    localparam int NREQ_DEF  = 4;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_IO   = 2;
    localparam int REQ_DBG  = 3;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_ISSUE = 2'd1,
        WR_HOLD  = 2'd2
    } wr_state_e;

    // The output register is the state: a held write is one the destination refused.
    function automatic wr_state_e wr_state(input logic we, input logic stall);
        wr_state_e st;
        case ({we, stall})
            2'b10:   st = WR_ISSUE;
            2'b11:   st = WR_HOLD;
            default: st = WR_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/demux_write_arbiter_if.sv
// Requester-side and demux-side signals of the writeback arbiter.
interface demux_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 20,
    parameter int AW   = 4
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*AW-1:0] req_addr;
    logic               dmx_stall;
    logic [DW-1:0]      dmx_in;
    logic [AW-1:0]      dmx_addr;
    logic               dmx_we;
    logic [GW-1:0]      dmx_gnt;

    modport slave (
        input  req_valid, req_data, req_addr, dmx_stall,
        output req_ready, dmx_in, dmx_addr, dmx_we, dmx_gnt
    );

    modport master (
        output req_valid, req_data, req_addr, dmx_stall,
        input  req_ready, dmx_in, dmx_addr, dmx_we, dmx_gnt
    );
endinterface

// File: rtl/demux_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr_i,
// wrapping modulo NREQ.
module demux_write_arbiter_rr_pick #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);
    localparam logic [IW:0]     NREQ_W = (IW+1)'(NREQ);
    localparam logic [NREQ-1:0] ONE_W  = {{(NREQ-1){1'b0}}, 1'b1};

    logic [IW:0]   sum_s;
    logic [IW:0]   cand_s;
    logic          hit_s;

    // Scan requesters starting at the pointer and keep the first valid one.
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        sum_s  = '0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s  = {1'b0, ptr_i} + (IW+1)'(k);
            cand_s = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
            hit_s  = !any_o && valid_i[cand_s[IW-1:0]];
            idx_o  = hit_s ? cand_s[IW-1:0] : idx_o;
            gnt_o  = gnt_o | (hit_s ? (ONE_W << cand_s[IW-1:0]) : '0);
            any_o  = any_o | hit_s;
        end
    end
endmodule

// File: rtl/demux_write_arbiter.sv
// Round-robin write arbiter feeding the 16-way writeback demux: one requester
// per cycle is registered onto the demux inputs; a destination stall freezes it.
module demux_write_arbiter
    import demux_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DATA_W,
    parameter int AW   = REGADDR_W
) (
    input logic                  clk,
    input logic                  rst_n,
    demux_write_arbiter_if.slave bus
);
    localparam int            IW   = $clog2(NREQ);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [DW-1:0]   in_q, in_d;
    logic [AW-1:0]   addr_q, addr_d;

    logic [NREQ-1:0] win_oh_s;
    logic [IW-1:0]   win_idx_s;
    logic            win_any_s;
    wr_state_e       state_s;
    logic            can_load_s;

    assign state_s    = wr_state(we_q, bus.dmx_stall);
    assign can_load_s = (state_s != WR_HOLD);

    demux_write_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (win_oh_s),
        .idx_o   (win_idx_s),
        .any_o   (win_any_s)
    );

    // Ready is held low during reset so nothing is considered accepted.
    assign bus.req_ready = (rst_n && can_load_s) ? win_oh_s : '0;

    // Next write: load the winner, drop to a zeroed idle, or hold on stall.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        in_d     = in_q;
        addr_d   = addr_q;
        if (can_load_s && win_any_s) begin
            we_d     = 1'b1;
            in_d     = bus.req_data[win_idx_s*DW +: DW];
            addr_d   = bus.req_addr[win_idx_s*AW +: AW];
            gnt_d    = win_idx_s;
            rr_ptr_d = (win_idx_s == LAST) ? '0 : (win_idx_s + IW'(1));
        end else if (can_load_s) begin
            we_d   = 1'b0;
            in_d   = '0;
            addr_d = '0;
        end else begin
            we_d = we_q;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            we_q     <= 1'b0;
            in_q     <= '0;
            addr_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            in_q     <= in_d;
            addr_q   <= addr_d;
        end
    end

    assign bus.dmx_we   = we_q;
    assign bus.dmx_in   = in_q;
    assign bus.dmx_addr = addr_q;
    assign bus.dmx_gnt  = gnt_q;
endmodule

// File: tb/tb_demux_write_arbiter.sv
// Bench for demux_write_arbiter: vector table with hand-derived grants, a
// scoreboard for the registered demux write, and reset/stall/fairness sequences.
module tb_demux_write_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 20;
    localparam int AW   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();
    demux_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [19:0] din;
        logic [3:0]  addr;
        logic [1:0]  gnt;
    } exp_t;

    typedef struct {
        logic [3:0]  valid;
        logic        stall;
        logic [19:0] d_base;
        logic [3:0]  a_base;
        logic [3:0]  exp_ready;
    } vec_t;

    exp_t sb_q[$];
    exp_t cur;
    int   m_ptr;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (v[i]) return 4'b0001 << i;
        end
        return 4'b0000;
    endfunction

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'(4'b0000));
        check({tag, ".we"},    32'(bus.dmx_we),    32'(1'b0));
        check({tag, ".din"},   32'(bus.dmx_in),    32'(20'h0));
        check({tag, ".addr"},  32'(bus.dmx_addr),  32'(4'h0));
        check({tag, ".gnt"},   32'(bus.dmx_gnt),   32'(2'd0));
    endtask

    // Called just after a rising edge; drives one cycle and checks ready and the registered write.
    task automatic drive_cycle(input logic [3:0] v, input logic [79:0] d, input logic [15:0] a,
                               input logic s, input logic [3:0] exp_ready, input string tag);
        exp_t nxt;
        exp_t got;
        int   g;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_addr  = a;
        bus.dmx_stall = s;
        @(negedge clk);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'(exp_ready));
        nxt = cur;
        if (exp_ready != 4'b0000) begin
            g        = oh2idx(exp_ready);
            nxt.we   = 1'b1;
            nxt.din  = d[g*20 +: 20];
            nxt.addr = a[g*4 +: 4];
            nxt.gnt  = 2'(g);
            m_ptr    = (g + 1) % 4;
        end else if (!(cur.we && s)) begin
            nxt.we   = 1'b0;
            nxt.din  = 20'h0;
            nxt.addr = 4'h0;
        end
        sb_q.push_back(nxt);
        cur = nxt;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({tag, ".we"},   32'(bus.dmx_we),   32'(got.we));
        check({tag, ".din"},  32'(bus.dmx_in),   32'(got.din));
        check({tag, ".addr"}, 32'(bus.dmx_addr), 32'(got.addr));
        check({tag, ".gnt"},  32'(bus.dmx_gnt),  32'(got.gnt));
    endtask

    function automatic logic [79:0] pack_d(input logic [19:0] base);
        logic [79:0] r;
        r = 80'h0;
        for (int i = 0; i < 4; i++) r[i*20 +: 20] = base ^ {4'(i), 16'h0};
        return r;
    endfunction

    function automatic logic [15:0] pack_a(input logic [3:0] base);
        logic [15:0] r;
        r = 16'h0;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = base + 4'(i);
        return r;
    endfunction

    initial begin
        logic [79:0] d;
        logic [15:0] a;
        logic [3:0]  v;
        int          since;

        vecs[0]  = '{4'b1111, 1'b0, 20'h10101, 4'h0, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b0, 20'h20202, 4'h1, 4'b0010};
        vecs[2]  = '{4'b1111, 1'b0, 20'h30303, 4'h2, 4'b0100};
        vecs[3]  = '{4'b1111, 1'b0, 20'h40404, 4'h3, 4'b1000};
        vecs[4]  = '{4'b1111, 1'b0, 20'h50505, 4'h4, 4'b0001};
        vecs[5]  = '{4'b1111, 1'b0, 20'h5A5A5, 4'h2, 4'b0010};
        vecs[6]  = '{4'b1111, 1'b1, 20'h5A5A5, 4'h2, 4'b0000};
        vecs[7]  = '{4'b1111, 1'b1, 20'h5A5A5, 4'h2, 4'b0000};
        vecs[8]  = '{4'b1111, 1'b1, 20'h5A5A5, 4'h2, 4'b0000};
        vecs[9]  = '{4'b1111, 1'b0, 20'h5A5A5, 4'h2, 4'b0100};
        vecs[10] = '{4'b0001, 1'b1, 20'h0F0F0, 4'h9, 4'b0000};
        vecs[11] = '{4'b0001, 1'b0, 20'h0F0F0, 4'h9, 4'b0001};
        vecs[12] = '{4'b0000, 1'b1, 20'h77777, 4'hA, 4'b0000};
        vecs[13] = '{4'b0000, 1'b0, 20'h77777, 4'hA, 4'b0000};
        vecs[14] = '{4'b0001, 1'b1, 20'hC0FFE, 4'hB, 4'b0001};
        vecs[15] = '{4'b1001, 1'b0, 20'h12345, 4'h5, 4'b1000};
        vecs[16] = '{4'b1001, 1'b0, 20'h6789A, 4'h8, 4'b0001};
        vecs[17] = '{4'b0000, 1'b0, 20'h6789A, 4'h8, 4'b0000};

        cur           = '{we: 1'b0, din: 20'h0, addr: 4'h0, gnt: 2'd0};
        m_ptr         = 0;
        bus.req_valid = 4'b1111;
        bus.req_data  = pack_d(20'hFFFFF);
        bus.req_addr  = pack_a(4'hF);
        bus.dmx_stall = 1'b0;

        repeat (2) @(posedge clk);
        #3;
        check_reset("reset");
        bus.req_valid = 4'b0000;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        d = {20'h33333, 20'hABCDE, 20'h22222, 20'h11111};
        a = {4'h1, 4'h7, 4'h2, 4'h3};
        drive_cycle(4'b0100, d, a, 1'b0, 4'b0100, "single");
        drive_cycle(4'b0000, d, a, 1'b0, 4'b0000, "idle_zero");

        drive_cycle(4'b0001, d, a, 1'b0, 4'b0001, "hold_pre");
        drive_cycle(4'b0000, d, a, 1'b1, 4'b0000, "hold");
        #2;
        bus.req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        check_reset("reset_in_hold");
        bus.req_valid = 4'b0000;
        bus.dmx_stall = 1'b0;
        cur   = '{we: 1'b0, din: 20'h0, addr: 4'h0, gnt: 2'd0};
        m_ptr = 0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive_cycle(vecs[i].valid, pack_d(vecs[i].d_base), pack_a(vecs[i].a_base),
                        vecs[i].stall, vecs[i].exp_ready, $sformatf("vec%0d", i));
        end

        since = 0;
        for (int i = 0; i < 24; i++) begin
            v = {1'b1, 3'($urandom_range(0, 7))};
            drive_cycle(v, pack_d(20'(i * 4099)), pack_a(4'(i)), 1'b0,
                        model_pick(v, m_ptr), $sformatf("starve%0d", i));
            since++;
            if (bus.dmx_gnt == 2'd3) begin
                check("starve_gap", 32'(since <= 4), 32'(1'b1));
                since = 0;
            end
        end
        check("starve_tail", 32'(since <= 3), 32'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
